// File: rtl/secuenciador_instr_if.sv
// Sequencer bus: memory fetch handshake, decoder hand-off and status lines.
// With SECUENCIADOR_STEP_EN defined the bus also carries the single-step input.
interface secuenciador_instr_if #(
  parameter int PC_W = 5
);
  logic            start;
  logic            mem_ack;
  logic [7:0]      mem_data;
  logic [1:0]      flags;
  logic            done_in;
`ifdef SECUENCIADOR_STEP_EN
  logic            step;
`endif
  logic            mem_req;
  logic [PC_W-1:0] pc;
  logic [2:0]      inst;
  logic [1:0]      cond;
  logic            exec;
  logic            busy;
  logic            halted;
  logic            err;

  // Sequencer side: consumes memory/decoder responses, drives request and status.
  modport master (
    input  start,
    input  mem_ack,
    input  mem_data,
    input  flags,
    input  done_in,
`ifdef SECUENCIADOR_STEP_EN
    input  step,
`endif
    output mem_req,
    output pc,
    output inst,
    output cond,
    output exec,
    output busy,
    output halted,
    output err
  );

  // Environment side: program memory, control decoder and datapath flags.
  modport slave (
    output start,
    output mem_ack,
    output mem_data,
    output flags,
    output done_in,
`ifdef SECUENCIADOR_STEP_EN
    output step,
`endif
    input  mem_req,
    input  pc,
    input  inst,
    input  cond,
    input  exec,
    input  busy,
    input  halted,
    input  err
  );
endinterface

// File: rtl/secuenciador_instr.sv
// secuenciador_instr: multi-cycle instruction sequencer for the 3-bit-opcode core.
// IDLE -> FETCH -> DECODE -> [EXEC] -> NEXT -> FETCH ..., HALT on opcode 000 or
// fetch timeout. Every output is a register loaded from the next-state decode.
// Optional feature macro: SECUENCIADOR_STEP_EN adds a WAIT state after NEXT that
// holds until bus.step is high (step in the NEXT cycle itself skips the wait).
module secuenciador_instr #(
  parameter int PC_W     = 5,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input logic                  clk,
  input logic                  rst,
  secuenciador_instr_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
`ifdef SECUENCIADOR_STEP_EN
  localparam logic [2:0] S_WAIT   = 3'd6;
`endif

  localparam logic [2:0] OP_HALT = 3'b000;
  localparam logic [2:0] OP_JUMP = 3'b111;

  // Counter only has to reach TIMEOUT-1.
  localparam int              TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  // Architectural state
  logic [2:0]      state_q, state_d;
  logic [7:0]      ir_q, ir_d;
  logic [1:0]      flg_q, flg_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            jump_q, jump_d;
  logic [TO_W-1:0] to_q, to_d;
  logic            err_q, err_d;

  // Registered outputs
  logic            mem_req_q, mem_req_d;
  logic [2:0]      inst_q, inst_d;
  logic [1:0]      cond_q, cond_d;
  logic            exec_q, exec_d;
  logic            busy_q, busy_d;
  logic            halted_q, halted_d;

  // Jump target: 5-bit operand zero-extended or truncated to the PC width.
  function automatic logic [PC_W-1:0] jump_target(input logic [4:0] operand);
    return PC_W'(operand);
  endfunction

  // Sequential increment, wrapping modulo 2^PC_W.
  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    return pc + PC_W'(1);
  endfunction

  // True on the last FETCH cycle allowed without an acknowledge.
  function automatic logic timeout_hit(input logic [TO_W-1:0] cnt);
    return (TIMEOUT != 0) && (cnt == TO_W'(TIMEOUT - 1));
  endfunction

  function automatic logic is_busy(input logic [2:0] st);
    logic b;
    b = (st == S_FETCH) || (st == S_DECODE) || (st == S_EXEC) || (st == S_NEXT);
`ifdef SECUENCIADOR_STEP_EN
    b = b || (st == S_WAIT);
`endif
    return b;
  endfunction

  // Next-state, instruction capture, PC management and fetch timeout.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    flg_d   = flg_q;
    pc_d    = pc_q;
    jump_d  = jump_q;
    to_d    = to_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        // An acknowledge on the limit cycle still counts as a normal fetch.
        if (bus.mem_ack) begin
          ir_d    = bus.mem_data;
          flg_d   = bus.flags;
          to_d    = '0;
          state_d = S_DECODE;
        end else if (timeout_hit(to_q)) begin
          err_d   = 1'b1;
          to_d    = '0;
          state_d = S_HALT;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_DECODE: begin
        if (ir_q[7:5] == OP_HALT) state_d = S_HALT;
        else if (!bus.done_in)    state_d = S_NEXT;
        else                      state_d = S_EXEC;
      end
      S_EXEC: begin
        // The jump flag stops NEXT from incrementing over the new target.
        if (ir_q[7:5] == OP_JUMP) begin
          pc_d   = jump_target(ir_q[4:0]);
          jump_d = 1'b1;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (jump_q) jump_d = 1'b0;
        else        pc_d   = pc_inc(pc_q);
`ifdef SECUENCIADOR_STEP_EN
        state_d = bus.step ? S_FETCH : S_WAIT;
`else
        state_d = S_FETCH;
`endif
      end
`ifdef SECUENCIADOR_STEP_EN
      S_WAIT: begin
        if (bus.step) state_d = S_FETCH;
      end
`endif
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next state; the decoder sees 000/00 outside DECODE/EXEC.
  always_comb begin
    mem_req_d = (state_d == S_FETCH);
    exec_d    = (state_d == S_EXEC);
    halted_d  = (state_d == S_HALT);
    busy_d    = is_busy(state_d);
    inst_d    = '0;
    cond_d    = '0;
    if ((state_d == S_DECODE) || (state_d == S_EXEC)) begin
      inst_d = ir_d[7:5];
      cond_d = flg_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      flg_q     <= '0;
      pc_q      <= PC_RST;
      jump_q    <= 1'b0;
      to_q      <= '0;
      err_q     <= 1'b0;
      mem_req_q <= 1'b0;
      inst_q    <= '0;
      cond_q    <= '0;
      exec_q    <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      flg_q     <= flg_d;
      pc_q      <= pc_d;
      jump_q    <= jump_d;
      to_q      <= to_d;
      err_q     <= err_d;
      mem_req_q <= mem_req_d;
      inst_q    <= inst_d;
      cond_q    <= cond_d;
      exec_q    <= exec_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
    end
  end

  assign bus.mem_req = mem_req_q;
  assign bus.pc      = pc_q;
  assign bus.inst    = inst_q;
  assign bus.cond    = cond_q;
  assign bus.exec    = exec_q;
  assign bus.busy    = busy_q;
  assign bus.halted  = halted_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_secuenciador_instr.sv
// Testbench for secuenciador_instr: a program-level model predicts fetch
// addresses, EXEC strobes and halts with their cycle stamps into a queue; a
// monitor pops and compares whenever the DUT shows one of those events.
module tb_secuenciador_instr;
  localparam int PC_W    = 5;
  localparam int PC_SPAN = 1 << PC_W;
  localparam int TIMEOUT = 15;

  localparam int EV_FETCH = 0;
  localparam int EV_EXEC  = 1;
  localparam int EV_HALT  = 2;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  typedef struct {
    int kind;
    int cyc;
    int a;
    int b;
  } ev_t;

  logic clk;
  logic rst;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  secuenciador_instr_if #(.PC_W(PC_W)) bus ();
  secuenciador_instr_if #(.PC_W(PC_W)) bus31 ();

  secuenciador_instr #(.PC_W(PC_W), .RESET_PC(0), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Second core reset to the top address, fed the same stimulus, to see PC wrap.
  secuenciador_instr #(.PC_W(PC_W), .RESET_PC(31), .TIMEOUT(TIMEOUT)) u_dut31 (
    .clk(clk), .rst(rst), .bus(bus31)
  );

  assign bus31.start    = bus.start;
  assign bus31.mem_ack  = bus.mem_ack;
  assign bus31.mem_data = bus.mem_data;
  assign bus31.flags    = bus.flags;
  assign bus31.done_in  = bus.done_in;
`ifdef SECUENCIADOR_STEP_EN
  initial bus.step = 1'b1;
  assign bus31.step = bus.step;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  ev_t        exp_q[$];
  logic [7:0] prog[PC_SPAN];
  bit         done_tab[PC_SPAN];
  int         m_mode     = M_IDLE;
  int         m_pc       = 0;
  int         next_fetch = 0;
  int         plan_delay = 0;
  int         fix_delay  = 0;
  bit         kick       = 0;
  bit         noise      = 0;
  bit         rst_req    = 0;

  function automatic string kname(input int k);
    case (k)
      EV_FETCH: return "fetch";
      EV_EXEC:  return "exec";
      EV_HALT:  return "halt";
      default:  return "none";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int at, input int a, input int b);
    ev_t e;
    e.kind = kind; e.cyc = at; e.a = a; e.b = b;
    exp_q.push_back(e);
  endtask

  task automatic sched_fetch(input int at);
    next_fetch = at;
    plan_delay = (fix_delay >= 0) ? fix_delay : $urandom_range(0, 3);
    push_ev(EV_FETCH, at, m_pc, 0);
  endtask

  // One clock of stimulus; the model advances by program semantics.
  task automatic step_cycle();
    int         c;
    int         age;
    int         op;
    bit         d;
    logic [7:0] w;
    @(posedge clk);
    #1;
    c            = cyc;
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'($urandom);
    bus.flags    = 2'($urandom);
    if (rst_req) begin
      rst_req     = 0;
      rst         = 1'b1;
      bus.mem_ack = 1'b1;
      exp_q.delete();
      m_mode      = M_IDLE;
      m_pc        = 0;
      return;
    end
    if (noise && m_mode != M_IDLE) bus.start = ($urandom_range(0, 3) == 0);
    case (m_mode)
      M_IDLE: begin
        if (kick) begin
          kick      = 0;
          bus.start = 1'b1;
          m_mode    = M_RUN;
          sched_fetch(c + 1);
        end else if (noise) begin
          bus.mem_ack = ($urandom_range(0, 2) == 0);
        end
      end
      M_RUN: begin
        if (c >= next_fetch) begin
          age = c - next_fetch;
          if (age == plan_delay) begin
            w            = prog[m_pc];
            d            = done_tab[m_pc];
            bus.mem_ack  = 1'b1;
            bus.mem_data = w;
            bus.done_in  = d;
            op           = int'(w[7:5]);
            if (op == 0) begin
              push_ev(EV_HALT, c + 2, 0, 0);
              m_mode = M_HALT;
            end else if (!d) begin
              m_pc = (m_pc + 1) % PC_SPAN;
              sched_fetch(c + 3);
            end else begin
              push_ev(EV_EXEC, c + 2, op, int'(bus.flags));
              m_pc = (op == 7) ? (int'(w[4:0]) % PC_SPAN) : ((m_pc + 1) % PC_SPAN);
              sched_fetch(c + 4);
            end
          end else if (age == TIMEOUT - 1) begin
            push_ev(EV_HALT, c + 1, 1, 0);
            m_mode = M_HALT;
          end
        end else if (noise) begin
          bus.mem_ack = ($urandom_range(0, 2) == 0);
        end
      end
      default: begin
        if (noise) bus.mem_ack = 1'($urandom_range(0, 1));
      end
    endcase
  endtask

  task automatic do_reset();
    rst_req = 1;
    step_cycle();
    step_cycle();
  endtask

  task automatic check_reset();
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_pc", bus.pc, 0);
    check("rst_inst", bus.inst, 0);
    check("rst_cond", bus.cond, 0);
    check("rst_exec", bus.exec, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_halted", bus.halted, 0);
    check("rst_err", bus.err, 0);
    check("rst_pc31", bus31.pc, 31);
  endtask

  task automatic run_until_halt(input int budget);
    int n = 0;
    while (m_mode != M_HALT && n < budget) begin
      step_cycle();
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      step_cycle();
      n++;
    end
    check("events_pending", exp_q.size(), 0);
  endtask

  // Monitor: every observable event must match the head of the expected queue.
  task automatic mon_event(input int kind, input int a, input int b);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got a=%0d b=%0d at cycle %0d, expected no event",
               kname(kind), a, b, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.a != a || e.b != b) begin
        errors++;
        $display("FAIL %s: got %s cyc=%0d a=%0d b=%0d expected %s cyc=%0d a=%0d b=%0d",
                 kname(e.kind), kname(kind), cyc, a, b, kname(e.kind), e.cyc, e.a, e.b);
      end
    end
  endtask

  initial begin
    bit prev_req  = 0;
    bit prev_halt = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (bus.exec === 1'b1) mon_event(EV_EXEC, int'(bus.inst), int'(bus.cond));
        if (bus.mem_req === 1'b1 && !prev_req) mon_event(EV_FETCH, int'(bus.pc), 0);
        if (bus.halted === 1'b1 && !prev_halt) mon_event(EV_HALT, int'(bus.err), 0);
        if (bus.mem_req === 1'b1 || bus.halted === 1'b1) begin
          check("decoder_safe", int'({bus.inst, bus.cond, bus.exec}), 0);
          check("busy", int'(bus.busy), int'(bus.mem_req));
        end
      end
      prev_req  = (bus.mem_req === 1'b1);
      prev_halt = (bus.halted === 1'b1);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.mem_ack  = 1'b0;
    bus.mem_data = 8'h00;
    bus.flags    = 2'b00;
    bus.done_in  = 1'b0;
    for (int i = 0; i < PC_SPAN; i++) begin
      prog[i]     = 8'b010_00001;
      done_tab[i] = 1'b1;
    end

    // Reset state
    do_reset();
    check_reset();

    // Plain instruction, taken jump, not-taken conditional, halt
    prog[0]  = 8'b010_00011; done_tab[0]  = 1'b1;
    prog[1]  = 8'b111_10100; done_tab[1]  = 1'b1;
    prog[20] = 8'b111_10100; done_tab[20] = 1'b0;
    prog[21] = 8'h00;
    fix_delay = 0;
    kick      = 1;
    step_cycle();
    step_cycle();
    check("wrap_first_req", bus31.mem_req, 1);
    check("wrap_first_pc", bus31.pc, 31);
    repeat (4) step_cycle();
    check("wrap_next_req", bus31.mem_req, 1);
    check("wrap_next_pc", bus31.pc, 0);
    run_until_halt(60);
    drain();

    // HALT ignores START and ACK
    noise = 1;
    repeat (20) step_cycle();
    noise = 0;
    check("halt_hold_halted", bus.halted, 1);
    check("halt_hold_busy", bus.busy, 0);
    check("halt_hold_pc", bus.pc, m_pc);

    // Reset while MEM_REQ is high with an ACK in the same cycle
    do_reset();
    prog[0] = 8'b011_00101; done_tab[0] = 1'b1;
    prog[1] = 8'h00;
    fix_delay = 3;
    kick      = 1;
    step_cycle();
    step_cycle();
    rst_req = 1;
    step_cycle();
    check("pre_rst_req", bus.mem_req, 1);
    step_cycle();
    check_reset();
    fix_delay = 0;
    kick      = 1;
    run_until_halt(60);
    drain();

    // Fetch timeout, then ACK exactly on the limit cycle
    do_reset();
    prog[0] = 8'b010_00001; done_tab[0] = 1'b1;
    prog[1] = 8'h00;
    fix_delay = 99;
    kick      = 1;
    run_until_halt(60);
    drain();
    check("timeout_err", bus.err, 1);
    check("timeout_req", bus.mem_req, 0);
    do_reset();
    check("err_cleared", bus.err, 0);
    fix_delay = TIMEOUT - 1;
    kick      = 1;
    run_until_halt(80);
    drain();
    check("limit_ack_err", bus.err, 0);

    // Randomized programs with random ACK latency, flags, DONE and noise
    for (int r = 0; r < 20; r++) begin
      do_reset();
      for (int i = 0; i < PC_SPAN; i++) begin
        if ($urandom_range(0, 15) == 0) prog[i] = {3'b000, 5'($urandom)};
        else                            prog[i] = {3'($urandom_range(1, 7)), 5'($urandom)};
        done_tab[i] = ($urandom_range(0, 3) != 0);
      end
      fix_delay = -1;
      noise     = 1;
      kick      = 1;
      run_until_halt(200);
      if (m_mode == M_HALT) drain();
      noise = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
